// File: rtl/ad1_sample_sched.sv
// ad1_sample_sched: sample-rate scheduler and handshake controller for the
// dual-channel AD1 serial ADC front end.
//
// A programmable tick counter issues periodic conversion requests on adcdav.
// The davadc acknowledge is awaited with a timeout. Both 12-bit channel
// results are latched into a valid/ack holding register for the consumer.
// Overrun, timeout and missed-tick events are reported.
//
// Ports:
//   bufclk, rstn          clock, async active-low reset
//   enable, oneshot       run control; oneshot = one conversion per enable rise
//   period                tick interval minus one (bufclk cycles)
//   adcdav / davadc       ADC request (out) / done acknowledge (in)
//   adc0data, adc1data    ADC results, stable while davadc=1
//   smp_valid / smp_ack   holding register valid (out) / consumer accept (in)
//   smp_ch0, smp_ch1      held sample pair
//   overrun, timeout_err  sticky flags; missed = saturating busy-tick count
//   clr_flags             synchronous clear of overrun, timeout_err, missed
//
// Optional feature: define AD1_SCHED_AVG_EN to present the average of every
// 4 conversions per channel instead of each raw conversion.

module ad1_sample_sched #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                bufclk,
  input  logic                rstn,
  input  logic                enable,
  input  logic                oneshot,
  input  logic [PERIOD_W-1:0] period,
  output logic                adcdav,
  input  logic                davadc,
  input  logic [11:0]         adc0data,
  input  logic [11:0]         adc1data,
  output logic                smp_valid,
  input  logic                smp_ack,
  output logic [11:0]         smp_ch0,
  output logic [11:0]         smp_ch1,
  output logic                overrun,
  output logic                timeout_err,
  output logic [7:0]          missed,
  input  logic                clr_flags
);

  localparam int unsigned DATA_W = 12;
  localparam int unsigned MISS_W = 8;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] tick_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                enable_q;
  logic                armed;

  logic                tick_c;
  logic                rise_c;
  logic                go_c;
  logic                capture_c;
  logic                abort_c;
  logic                miss_c;
  logic                deliver_c;
  logic [DATA_W-1:0]   out0_c;
  logic [DATA_W-1:0]   out1_c;

  logic                adcdav_nxt;
  logic                valid_nxt;
  logic [DATA_W-1:0]   ch0_nxt;
  logic [DATA_W-1:0]   ch1_nxt;
  logic                overrun_nxt;
  logic                timeout_nxt;
  logic [MISS_W-1:0]   missed_nxt;

  // Tick generation: count 0..period, tick on the wrap cycle.
  assign tick_c = enable && (tick_cnt >= period);

  always_ff @(posedge bufclk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
    end else if (!enable || tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PERIOD_W'(1);
    end
  end

  // Oneshot arming: an enable rising edge permits exactly one request.
  assign rise_c = enable && !enable_q;
  assign go_c   = (state == S_IDLE) && tick_c && (!oneshot || armed || rise_c);

  always_ff @(posedge bufclk or negedge rstn) begin
    if (!rstn) begin
      enable_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      enable_q <= enable;
      if (!enable || go_c) begin
        armed <= 1'b0;
      end else if (rise_c) begin
        armed <= 1'b1;
      end
    end
  end

  // Request timeout: counts cycles spent in REQ; abort on the last one.
  always_ff @(posedge bufclk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (state == S_REQ) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign capture_c = (state == S_REQ) && davadc;
  assign abort_c   = (state == S_REQ) && !davadc && (to_cnt == TO_W'(TIMEOUT - 1));
  assign miss_c    = tick_c && (state != S_IDLE);

  // State register.
  always_ff @(posedge bufclk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (go_c) state_nxt = S_REQ;
      S_REQ:     if (capture_c || abort_c) state_nxt = S_RELEASE;
      S_RELEASE: if (!davadc) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

`ifdef AD1_SCHED_AVG_EN
  // Averaging: sum 4 conversions per channel, present sum >> 2.
  logic [13:0] acc0, acc1;
  logic [1:0]  grp_cnt;
  logic [13:0] sum0_c, sum1_c;

  assign sum0_c    = acc0 + 14'(adc0data);
  assign sum1_c    = acc1 + 14'(adc1data);
  assign deliver_c = capture_c && (grp_cnt == 2'd3);
  assign out0_c    = sum0_c[13:2];
  assign out1_c    = sum1_c[13:2];

  always_ff @(posedge bufclk or negedge rstn) begin
    if (!rstn) begin
      acc0    <= '0;
      acc1    <= '0;
      grp_cnt <= '0;
    end else if (abort_c || deliver_c) begin
      acc0    <= '0;
      acc1    <= '0;
      grp_cnt <= '0;
    end else if (capture_c) begin
      acc0    <= sum0_c;
      acc1    <= sum1_c;
      grp_cnt <= grp_cnt + 2'd1;
    end
  end
`else
  // Every conversion goes straight to the holding register.
  assign deliver_c = capture_c;
  assign out0_c    = adc0data;
  assign out1_c    = adc1data;
`endif

  // Output logic: next values for the registered outputs.
  always_comb begin
    adcdav_nxt  = (state_nxt == S_REQ);
    valid_nxt   = smp_valid;
    ch0_nxt     = smp_ch0;
    ch1_nxt     = smp_ch1;
    overrun_nxt = clr_flags ? 1'b0 : overrun;
    timeout_nxt = clr_flags ? 1'b0 : timeout_err;
    missed_nxt  = clr_flags ? '0 : missed;

    if (smp_valid && smp_ack) begin
      valid_nxt = 1'b0;
    end
    // A new sample overrides the ack; only an un-acked overwrite is an overrun.
    if (deliver_c) begin
      valid_nxt = 1'b1;
      ch0_nxt   = out0_c;
      ch1_nxt   = out1_c;
      if (smp_valid && !smp_ack) begin
        overrun_nxt = 1'b1;
      end
    end
    if (abort_c) begin
      timeout_nxt = 1'b1;
    end
    if (miss_c && (missed_nxt != {MISS_W{1'b1}})) begin
      missed_nxt = missed_nxt + MISS_W'(1);
    end
  end

  // Output registers; adcdav clears asynchronously on reset.
  always_ff @(posedge bufclk or negedge rstn) begin
    if (!rstn) begin
      adcdav      <= 1'b0;
      smp_valid   <= 1'b0;
      smp_ch0     <= '0;
      smp_ch1     <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      missed      <= '0;
    end else begin
      adcdav      <= adcdav_nxt;
      smp_valid   <= valid_nxt;
      smp_ch0     <= ch0_nxt;
      smp_ch1     <= ch1_nxt;
      overrun     <= overrun_nxt;
      timeout_err <= timeout_nxt;
      missed      <= missed_nxt;
    end
  end

endmodule
